// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and address-split helpers shared by data_cache_wb.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill
  } state_e;

  localparam int unsigned AddrBits    = 32;
  localparam int unsigned ByteOffBits = 2;

  // Tag width left over once byte, word and index fields are carved off the address.
  function automatic int unsigned tag_bits(input int unsigned setnum, input int unsigned words);
    return AddrBits - ByteOffBits - $clog2(setnum) - $clog2(words);
  endfunction

endpackage

// File: rtl/data_cache_wb_if.sv
// data_cache_wb_if: word-beat memory bus between the cache (master) and backing memory (slave).
interface data_cache_wb_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_lru.sv
// cache_lru: true-LRU age update and victim selection for one set (purely combinational).
module cache_lru #(
  parameter  int unsigned DEGREE = 2,
  localparam int unsigned AW     = $clog2(DEGREE)
) (
  input  logic [DEGREE-1:0][AW-1:0] age_i,
  input  logic [DEGREE-1:0]         valid_i,
  input  logic [AW-1:0]             way_i,
  output logic [DEGREE-1:0][AW-1:0] age_o,
  output logic [AW-1:0]             victim_o
);

  // Accessed way becomes youngest; every way younger than it ages by one.
  always_comb begin
    age_o = age_i;
    for (int w = 0; w < DEGREE; w++) begin
      if (AW'(w) == way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < age_i[way_i]) begin
        age_o[w] = age_i[w] + AW'(1);
      end
    end
  end

  // First invalid way wins; otherwise the way whose age is DEGREE-1.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_o = '0;
    for (int w = 0; w < DEGREE; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < DEGREE; w++) begin
        if (age_i[w] == AW'(DEGREE - 1)) victim_o = AW'(w);
      end
    end
  end

endmodule

// File: rtl/data_cache_wb.sv
// data_cache_wb: set-associative write-back data cache with true-LRU replacement.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
// WORDS and SETNUM must be at least 2.
module data_cache_wb
  import cache_pkg::*;
#(
  parameter int unsigned SETNUM = 8,
  parameter int unsigned DEGREE = 2,
  parameter int unsigned WORDS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addressIn,
  input  logic [31:0]            dataIn,
  input  logic [3:0]             byteEn,
  input  logic                   loadMemory,
  input  logic                   storeMemory,
  output logic [31:0]            dataOut,
  output logic                   hit,
  output logic                   stall,
  data_cache_wb_if.master        mem
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            hitCount,
  output logic [31:0]            missCount
`endif
);

  localparam int unsigned WBits = $clog2(WORDS);
  localparam int unsigned IBits = $clog2(SETNUM);
  localparam int unsigned TBits = tag_bits(SETNUM, WORDS);
  localparam int unsigned AW    = $clog2(DEGREE);

  logic [WBits-1:0] word;
  logic [IBits-1:0] idx;
  logic [TBits-1:0] tag;
  logic [1:0]       unused_byte_off;

  assign word            = addressIn[ByteOffBits +: WBits];
  assign idx             = addressIn[ByteOffBits + WBits +: IBits];
  assign tag             = addressIn[AddrBits-1 -: TBits];
  assign unused_byte_off = addressIn[1:0];

  logic [SETNUM-1:0][DEGREE-1:0]         valid_q, dirty_q;
  logic [SETNUM-1:0][DEGREE-1:0][AW-1:0] age_q;
  logic [TBits-1:0]                      tag_q  [SETNUM][DEGREE];
  logic [31:0]                           data_q [SETNUM][DEGREE][WORDS];

  state_e           state_q, state_d;
  logic [WBits-1:0] beat_q, beat_d;
  logic [AW-1:0]    victim_q;
  logic [TBits-1:0] victim_tag_q, req_tag_q;
  logic [IBits-1:0] req_idx_q;

  logic                         req, is_store, is_load, match, idle, hit_acc, store_hit;
  logic [AW-1:0]                hit_way, victim;
  logic [DEGREE-1:0][AW-1:0]    age_upd;
  logic                         last_beat, miss_start, wb_done, refill_we, refill_done;
  logic                         bus_req, bus_we;
  logic [31:0]                  bus_addr, bus_wdata;

  assign req      = loadMemory | storeMemory;
  assign is_store = storeMemory;
  assign is_load  = loadMemory & ~storeMemory;

  // Tag compare across the ways of the addressed set.
  always_comb begin
    match   = 1'b0;
    hit_way = '0;
    for (int w = 0; w < DEGREE; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        match   = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  cache_lru #(
    .DEGREE (DEGREE)
  ) u_lru (
    .age_i    (age_q[idx]),
    .valid_i  (valid_q[idx]),
    .way_i    (hit_way),
    .age_o    (age_upd),
    .victim_o (victim)
  );

  assign idle      = (state_q == StIdle);
  assign hit_acc   = idle & req & match;
  assign store_hit = hit_acc & is_store;
  assign hit       = hit_acc;
  assign dataOut   = (hit_acc && is_load) ? data_q[idx][hit_way][word] : '0;
  assign stall     = !idle || (req && !match);
  assign last_beat = (beat_q == WBits'(WORDS - 1));

  // Next state, beat counter and memory bus drive.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    miss_start  = 1'b0;
    wb_done     = 1'b0;
    refill_we   = 1'b0;
    refill_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && !match) begin
          miss_start = 1'b1;
          beat_d     = '0;
          state_d    = (valid_q[idx][victim] && dirty_q[idx][victim]) ? StWriteback : StRefill;
        end
      end
      StWriteback: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {victim_tag_q, req_idx_q, beat_q, 2'b00};
        bus_wdata = data_q[req_idx_q][victim_q][beat_q];
        if (mem.mem_ack) begin
          beat_d = beat_q + WBits'(1);
          if (last_beat) begin
            wb_done = 1'b1;
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        bus_req   = 1'b1;
        bus_addr  = {req_tag_q, req_idx_q, beat_q, 2'b00};
        refill_we = mem.mem_ack;
        if (mem.mem_ack) begin
          beat_d = beat_q + WBits'(1);
          if (last_beat) begin
            refill_done = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem.mem_req   = bus_req;
  assign mem.mem_we    = bus_we;
  assign mem.mem_addr  = bus_addr;
  assign mem.mem_wdata = bus_wdata;

  // FSM state, beat counter and per-way valid/dirty/age bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETNUM; s++) begin
        for (int w = 0; w < DEGREE; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (hit_acc) age_q[idx] <= age_upd;
      if (store_hit) dirty_q[idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[req_idx_q][victim_q] <= 1'b0;
      if (refill_done) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
    end
  end

  // Line data, tags and the miss context latched at miss entry.
  always_ff @(posedge clk) begin
    if (miss_start) begin
      victim_q     <= victim;
      victim_tag_q <= tag_q[idx][victim];
      req_tag_q    <= tag;
      req_idx_q    <= idx;
    end
    if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) data_q[idx][hit_way][word][b*8 +: 8] <= dataIn[b*8 +: 8];
      end
    end
    if (refill_we) data_q[req_idx_q][victim_q][beat_q] <= mem.mem_rdata;
    if (refill_done) tag_q[req_idx_q][victim_q] <= req_tag_q;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Wrapping hit-cycle and miss-entry counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_acc) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_wb.sv
// tb_data_cache_wb: directed and randomized checks of data_cache_wb against a
// flat-memory / recency-list reference model.
module tb_data_cache_wb;

  localparam int unsigned SETNUM    = 8;
  localparam int unsigned DEGREE    = 2;
  localparam int unsigned WORDS     = 4;
  localparam int unsigned LineBytes = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addressIn, dataIn, dataOut;
  logic [3:0]  byteEn;
  logic        loadMemory, storeMemory, hit, stall;
`ifdef CACHE_STATS_EN
  logic [31:0] hitCount, missCount;
`endif

  data_cache_wb_if mem_if ();

  data_cache_wb #(
    .SETNUM (SETNUM),
    .DEGREE (DEGREE),
    .WORDS  (WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addressIn   (addressIn),
    .dataIn      (dataIn),
    .byteEn      (byteEn),
    .loadMemory  (loadMemory),
    .storeMemory (storeMemory),
    .dataOut     (dataOut),
    .hit         (hit),
    .stall       (stall),
    .mem         (mem_if)
`ifdef CACHE_STATS_EN
    ,
    .hitCount    (hitCount),
    .missCount   (missCount)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: flat memory image seen by the CPU, backing memory, per-set recency lists.
  logic [31:0] backing [int unsigned];
  logic [31:0] golden  [int unsigned];
  int unsigned sets    [SETNUM][$];
  bit          dirty_line [int unsigned];
  int unsigned exp_hits, exp_misses;
  int unsigned rd_beats, wr_beats;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;
  beat_t beats[$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_val(a);
  endfunction

  // Reset discards cached dirty data: the CPU view falls back to backing memory.
  task automatic model_reset();
    for (int s = 0; s < SETNUM; s++) sets[s].delete();
    dirty_line.delete();
    golden     = backing;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One CPU access, held until stall drops; serves memory beats with 'dly' wait cycles.
  task automatic access(input logic [31:0] a, input bit st, input bit both,
                        input logic [31:0] d, input logic [3:0] be, input int dly,
                        output logic first_hit, output logic [31:0] rdata);
    int unsigned line, s, v;
    int          pos, cd, n;
    bit          exp_hit;
    logic [31:0] g;
    line = a & ~(LineBytes - 1);
    s    = (a / LineBytes) % SETNUM;
    pos  = -1;
    foreach (sets[s][i]) if (sets[s][i] == line) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) begin
      sets[s].delete(pos);
    end else begin
      exp_misses++;
      if (sets[s].size() == DEGREE) begin
        v = sets[s].pop_back();
        if (dirty_line.exists(v)) begin
          for (int k = 0; k < WORDS; k++) beats.push_back('{v + 4 * k, 1'b1, gold_rd(v + 4 * k)});
          dirty_line.delete(v);
        end
      end
      for (int k = 0; k < WORDS; k++) beats.push_back('{line + 4 * k, 1'b0, 32'h0});
    end
    sets[s].push_front(line);
    exp_hits++;
    if (st) dirty_line[line] = 1'b1;

    addressIn   = a;
    dataIn      = d;
    byteEn      = be;
    storeMemory = st;
    loadMemory  = !st || both;
    #1;
    first_hit = hit;
    check_eq("stall_first", {31'b0, stall}, {31'b0, !exp_hit});
    check_eq("memreq_idle", {31'b0, mem_if.mem_req}, 32'd0);
    if (!st) check_eq("hit_first", {31'b0, hit}, {31'b0, exp_hit});

    cd = dly;
    n  = 0;
    while (stall && n < 300) begin
      if (mem_if.mem_req) begin
        if (beats.size() == 0) begin
          check_eq("beat_extra", {31'b0, mem_if.mem_req}, 32'd0);
        end else begin
          check_eq("beat_addr", mem_if.mem_addr, beats[0].addr);
          check_eq("beat_we", {31'b0, mem_if.mem_we}, {31'b0, beats[0].we});
          if (beats[0].we) check_eq("beat_wdata", mem_if.mem_wdata, beats[0].wdata);
          if (cd == 0) begin
            mem_if.mem_ack = 1'b1;
            if (beats[0].we) begin
              backing[beats[0].addr] = mem_if.mem_wdata;
              wr_beats++;
            end else begin
              mem_if.mem_rdata = mem_rd(beats[0].addr);
              rd_beats++;
            end
            void'(beats.pop_front());
            cd = dly;
          end else begin
            cd--;
          end
        end
      end
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      #1;
      n++;
    end
    check_eq("stall_done", {31'b0, stall}, 32'd0);
    check_eq("beats_left", beats.size(), 32'd0);
    beats.delete();
    rdata = dataOut;
    if (!st) begin
      check_eq("load_hit", {31'b0, hit}, 32'd1);
      check_eq("load_data", dataOut, gold_rd(a & ~32'h3));
    end else begin
      check_eq("store_dout", dataOut, 32'd0);
      g = gold_rd(a & ~32'h3);
      for (int b = 0; b < 4; b++) if (be[b]) g[b*8 +: 8] = d[b*8 +: 8];
      golden[a & ~32'h3] = g;
    end
    @(negedge clk);
    loadMemory  = 1'b0;
    storeMemory = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        fh, got;
    logic [31:0] rd;
    int unsigned r0, w0;
    int          n;
    rst              = 1'b1;
    addressIn        = '0;
    dataIn           = '0;
    byteEn           = '0;
    loadMemory       = 1'b0;
    storeMemory      = 1'b0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    rd_beats         = 0;
    wr_beats         = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_hit", {31'b0, hit}, 32'd0);
    check_eq("rst_stall", {31'b0, stall}, 32'd0);
    check_eq("rst_memreq", {31'b0, mem_if.mem_req}, 32'd0);
    check_eq("rst_dout", dataOut, 32'd0);
    for (int k = 0; k < 4; k++) backing[32'h100 + 4 * k] = 32'hA0 + k;
    model_reset();

    // First refill and read-back.
    r0 = rd_beats;
    access(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    check_eq("refill_beats", rd_beats - r0, 32'd4);
    check_eq("refill_data", rd, 32'hA0);

    // Partial store on a hit line.
    access(32'h104, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0011, 1, fh, rd);
    access(32'h104, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    check_eq("store_merge", rd, 32'h0000_BEEF);

    // LRU: 0x200 is the oldest when 0x300 arrives.
    access(32'h200, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    access(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    access(32'h300, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    access(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    check_eq("lru_keep_100", {31'b0, fh}, 32'd1);
    access(32'h200, 1'b0, 1'b0, 32'h0, 4'h0, 0, fh, rd);
    check_eq("lru_evict_200", {31'b0, fh}, 32'd0);

    // Dirty 0x100 is now oldest: its eviction writes back four beats.
    w0 = wr_beats;
    access(32'h500, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    check_eq("wb_beats", wr_beats - w0, 32'd4);
    check_eq("wb_mem_104", mem_rd(32'h104), 32'h0000_BEEF);

    // Stall mid-refill, then reset abandons the transfer.
    addressIn  = 32'h600;
    loadMemory = 1'b1;
    #1;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !(got && mem_if.mem_req && !mem_if.mem_we)) begin
      if (mem_if.mem_req) begin
        mem_if.mem_ack = 1'b1;
        if (mem_if.mem_we) begin
          backing[mem_if.mem_addr] = mem_if.mem_wdata;
        end else begin
          mem_if.mem_rdata = 32'h0;
          got              = 1'b1;
        end
      end
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      #1;
      n++;
    end
    check_eq("hold_reach", {31'b0, got}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      check_eq("hold_req", {31'b0, mem_if.mem_req}, 32'd1);
      check_eq("hold_addr", mem_if.mem_addr, 32'h604);
      check_eq("hold_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      #1;
    end
    rst        = 1'b1;
    loadMemory = 1'b0;
    @(negedge clk);
    #1;
    check_eq("abort_memreq", {31'b0, mem_if.mem_req}, 32'd0);
    check_eq("abort_hit", {31'b0, hit}, 32'd0);
    rst = 1'b0;
    model_reset();

    // After reset everything misses; two misses and one plain hit.
    access(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    check_eq("post_rst_miss", {31'b0, fh}, 32'd0);
    access(32'h104, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
    access(32'h200, 1'b0, 1'b0, 32'h0, 4'h0, 1, fh, rd);
`ifdef CACHE_STATS_EN
    check_eq("stat_hits", hitCount, 32'd3);
    check_eq("stat_misses", missCount, 32'd2);
`endif

    // Randomized traffic over a few conflicting lines in two sets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      bit          st, both;
      a    = ($urandom_range(0, 4) << 7) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      st   = ($urandom_range(0, 9) < 4);
      both = st && ($urandom_range(0, 3) == 0);
      access(a, st, both, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 2), fh, rd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
`ifdef CACHE_STATS_EN
    check_eq("stat_hits_end", hitCount, exp_hits);
    check_eq("stat_misses_end", missCount, exp_misses);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
